// File: rtl/regfile_dist_mp.sv
`default_nettype none
// ============================================================================
// Module      : regfile_dist_mp
// Description : Multi-write-port distributed register file. Every entry is
//               visible on a flattened parallel output bus. NWR direct write
//               ports (highest index wins on collisions), one streaming bulk
//               loader and a DEPTH-cycle clear sweep share the array.
//               Optional per-byte write enables: define REGFILE_BYTE_WE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_dist_mp #(
    parameter int               WIDTH   = 32,
    parameter int               DEPTH   = 32,
    parameter int               NWR     = 2,
    parameter logic [WIDTH-1:0] CLR_VAL = '0,
    localparam int              AW      = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NWR-1:0]         we,
    input  logic [NWR*AW-1:0]      w_addr,
    input  logic [NWR*WIDTH-1:0]   di,
`ifdef REGFILE_BYTE_WE_EN
    input  logic [NWR*(WIDTH/8)-1:0] be,
`endif
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [WIDTH-1:0]       s_data,
    input  logic                   s_last,
    input  logic                   clr_req,
    output logic                   busy,
    output logic [DEPTH*WIDTH-1:0] parallel_dout,
    output logic [DEPTH-1:0]       entry_valid
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;
`ifdef REGFILE_BYTE_WE_EN
    localparam int NB = WIDTH / 8;
`endif

    logic [0:0]       state;
    logic [AW-1:0]    ld_ptr;
    logic [AW-1:0]    clr_ptr;
    logic [DEPTH-1:0] valid_q;
    logic [WIDTH-1:0] ram [DEPTH];

    logic [AW-1:0]    wa [NWR];
    logic [WIDTH-1:0] wd [NWR];
    logic [NWR-1:0]   port_hit;   // port contributes a valid write this cycle
    logic             in_idle;
    logic             stream_fire;

    // Unpack the per-port address/data buses and decide which ports mark valid.
    for (genvar p = 0; p < NWR; p++) begin : g_port
        assign wa[p] = w_addr[p*AW +: AW];
        assign wd[p] = di[p*WIDTH +: WIDTH];
`ifdef REGFILE_BYTE_WE_EN
        assign port_hit[p] = we[p] & (|be[p*NB +: NB]);
`else
        assign port_hit[p] = we[p];
`endif
    end

    // Stream only moves when no direct port is active, so the two never collide.
    assign in_idle     = (state == ST_IDLE);
    assign s_ready     = in_idle & ~(|we);
    assign stream_fire = s_valid & s_ready;
    assign busy        = (state == ST_CLEAR);
    assign entry_valid = valid_q;

    // Flatten the array onto the parallel read bus.
    for (genvar i = 0; i < DEPTH; i++) begin : g_dout
        assign parallel_dout[i*WIDTH +: WIDTH] = ram[i];
    end

    // Array write: the sweep owns the array while clearing; otherwise stream,
    // then direct ports in ascending index so the highest port lands last.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            ram[clr_ptr] <= CLR_VAL;
        end else begin
            if (stream_fire) begin
                ram[ld_ptr] <= s_data;
            end
            for (int p = 0; p < NWR; p++) begin
`ifdef REGFILE_BYTE_WE_EN
                for (int k = 0; k < NB; k++) begin
                    if (we[p] && be[p*NB + k]) begin
                        ram[wa[p]][k*8 +: 8] <= wd[p][k*8 +: 8];
                    end
                end
`else
                if (we[p]) begin
                    ram[wa[p]] <= wd[p];
                end
`endif
            end
        end
    end

    // Control: sweep sequencing, load pointer and per-entry valid flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            ld_ptr  <= '0;
            clr_ptr <= '0;
            valid_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clr_req) begin
                        // Clear wins over any write landing on the same edge.
                        state   <= ST_CLEAR;
                        clr_ptr <= '0;
                        ld_ptr  <= '0;
                        valid_q <= '0;
                    end else begin
                        if (stream_fire) begin
                            valid_q[ld_ptr] <= 1'b1;
                            if (s_last || (ld_ptr == AW'(DEPTH - 1))) begin
                                ld_ptr <= '0;
                            end else begin
                                ld_ptr <= ld_ptr + 1'b1;
                            end
                        end
                        for (int p = 0; p < NWR; p++) begin
                            if (port_hit[p]) begin
                                valid_q[wa[p]] <= 1'b1;
                            end
                        end
                    end
                end
                ST_CLEAR: begin
                    if (clr_ptr == AW'(DEPTH - 1)) begin
                        state   <= ST_IDLE;
                        clr_ptr <= '0;
                    end else begin
                        clr_ptr <= clr_ptr + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
